uart_receive: RTL and testbench

Single-clock UART receiver that deserialises the line produced by the team's UART transmitter: one bit per clock, idle-high line, one start bit (0), `d_width` data bits LSB first, one stop bit (1). It sits at the far end of the serial link and delivers each received word through a valid/acknowledge handshake. It also flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_hold.sv | 36 +++
 rtl/uart_receive.sv | 87 ++++++++
 tb/tb_uart_receive.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame levels, default widths and FSM state encoding.
package uart_pkg;

  localparam int D_WIDTH = 6;
  localparam int C_WIDTH = 4;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Fixed encodings kept so existing netlists/waveform decoders stay valid.
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DATA    = 2'd1;
  localparam logic [1:0] S_STOP    = 2'd2;
  localparam logic [1:0] S_WAIT_HI = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = S_IDLE,
    DATA    = S_DATA,
    STOP    = S_STOP,
    WAIT_HI = S_WAIT_HI
  } state_t;

endpackage

// File: rtl/uart_rx_hold.sv
// Output holding register for the UART receiver: valid/ack handshake and sticky overrun.
module uart_rx_hold
  import uart_pkg::*;
#(
  parameter int d_width = D_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [d_width-1:0] load_data,
  input  logic               ack,
  output logic [d_width-1:0] data,
  output logic               valid,
  output logic               ovr
);

  // A new word always wins; an ack in the same cycle clears overrun instead of setting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
      ovr   <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
      if (valid && !ack)
        ovr <= 1'b1;
      else if (valid && ack)
        ovr <= 1'b0;
    end else if (valid && ack) begin
      valid <= 1'b0;
      ovr   <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receive.sv
// Single-clock UART receiver: one bit per clk, start/data(LSB first)/stop framing.
module uart_receive
  import uart_pkg::*;
#(
  parameter int d_width = D_WIDTH,
  parameter int c_width = C_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  input  logic               rx_ack,
  output logic [d_width-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_busy,
  output logic               rx_err,
  output logic               rx_ovr
);

  localparam logic [c_width-1:0] CNT_LAST = c_width'(d_width - 1);

  state_t             state;
  logic [d_width-1:0] shreg;
  logic [c_width-1:0] cnt;
  logic               load;

  // Shift register is complete during STOP, so a good stop bit loads it directly.
  assign load = (state == STOP) && (rx == STOP_BIT);

  // Deserialising FSM; busy and err are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      rx_busy <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      rx_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx == START_BIT) begin
            shreg   <= '0;
            cnt     <= '0;
            rx_busy <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          shreg <= {rx, shreg[d_width-1:1]};
          // Counter holds at its last value instead of stepping past d_width-1.
          if (cnt == CNT_LAST)
            state <= STOP;
          else
            cnt <= cnt + c_width'(1);
        end
        STOP: begin
          rx_busy <= 1'b0;
          if (rx == STOP_BIT) begin
            state <= IDLE;
          end else begin
            rx_err <= 1'b1;
            state  <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (rx == IDLE_LEVEL)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_rx_hold #(
    .d_width(d_width)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(shreg),
    .ack      (rx_ack),
    .data     (rx_data),
    .valid    (rx_valid),
    .ovr      (rx_ovr)
  );

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive: table of frames plus hand-written corner sequences.
module tb_uart_receive;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rx_ack;
  logic [5:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_err;
  logic       rx_ovr;

  int n_total = 0;
  int n_pass  = 0;

  uart_receive #(
    .d_width(6),
    .c_width(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rx_ack  (rx_ack),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_busy (rx_busy),
    .rx_err  (rx_err),
    .rx_ovr  (rx_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] data;
    logic       stop;
    logic       ack_stop;
    logic       ack_after;
    logic       exp_valid;
    logic [5:0] exp_data;
    logic       exp_err;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Start bit in cycle T; returns in cycle T+8 with rx still at the stop level.
  task automatic send_frame(input logic [5:0] d, input logic stop, input logic ack_stop,
                            output int busy_cnt, output logic pre_valid);
    busy_cnt = 0;
    rx = 1'b0;
    tick();
    if (rx_busy) busy_cnt++;
    for (int i = 0; i < 6; i++) begin
      rx = d[i];
      tick();
      if (rx_busy) busy_cnt++;
    end
    pre_valid = rx_valid;
    rx     = stop;
    rx_ack = ack_stop;
    tick();
    rx_ack = 1'b0;
    if (rx_busy) busy_cnt++;
  endtask

  initial begin
    int         bcnt;
    int         ecnt;
    int         vcnt;
    logic       pv;
    logic [5:0] b2b[3];

    vecs[0] = '{6'h15, 1'b1, 1'b0, 1'b0, 1'b1, 6'h15, 1'b0, 1'b0};
    vecs[1] = '{6'h2A, 1'b1, 1'b0, 1'b1, 1'b1, 6'h2A, 1'b0, 1'b1};
    vecs[2] = '{6'h15, 1'b1, 1'b0, 1'b0, 1'b1, 6'h15, 1'b0, 1'b0};
    vecs[3] = '{6'h2A, 1'b1, 1'b1, 1'b1, 1'b1, 6'h2A, 1'b0, 1'b0};
    vecs[4] = '{6'h33, 1'b1, 1'b0, 1'b0, 1'b1, 6'h33, 1'b0, 1'b0};
    vecs[5] = '{6'h0C, 1'b0, 1'b0, 1'b1, 1'b1, 6'h33, 1'b1, 1'b0};
    b2b[0] = 6'h00;
    b2b[1] = 6'h3F;
    b2b[2] = 6'h12;

    rst = 1'b1; rx = 1'b1; rx_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_data", 32'(rx_data), 32'h0);
    chk("reset_valid", 32'(rx_valid), 32'h0);
    chk("reset_busy", 32'(rx_busy), 32'h0);
    chk("reset_err", 32'(rx_err), 32'h0);
    chk("reset_ovr", 32'(rx_ovr), 32'h0);

    // Single frame 6'h2D: valid 8 cycles after start, busy for 7 cycles
    tick(); tick();
    send_frame(6'h2D, 1'b1, 1'b0, bcnt, pv);
    chk("single_pre_valid", 32'(pv), 32'h0);
    chk("single_valid", 32'(rx_valid), 32'h1);
    chk("single_data", 32'(rx_data), 32'h2D);
    chk("single_err", 32'(rx_err), 32'h0);
    chk("single_busy_cycles", 32'(bcnt), 32'd7);
    rx = 1'b1;

    // Handshake, then ack with nothing pending
    rx_ack = 1'b1; tick(); rx_ack = 1'b0;
    chk("ack_valid", 32'(rx_valid), 32'h0);
    chk("ack_data", 32'(rx_data), 32'h2D);
    rx_ack = 1'b1; tick(); rx_ack = 1'b0;
    tick();
    chk("idle_ack_valid", 32'(rx_valid), 32'h0);
    chk("idle_ack_data", 32'(rx_data), 32'h2D);
    chk("idle_ack_ovr", 32'(rx_ovr), 32'h0);

    // Table: overrun, ack-in-stop, framing error
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].ack_stop, bcnt, pv);
      chk($sformatf("vec%0d_valid", v), 32'(rx_valid), 32'(vecs[v].exp_valid));
      chk($sformatf("vec%0d_data", v), 32'(rx_data), 32'(vecs[v].exp_data));
      chk($sformatf("vec%0d_err", v), 32'(rx_err), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_ovr", v), 32'(rx_ovr), 32'(vecs[v].exp_ovr));
      rx = 1'b1;
      rx_ack = vecs[v].ack_after;
      tick();
      rx_ack = 1'b0;
      chk($sformatf("vec%0d_err_drop", v), 32'(rx_err), 32'h0);
      if (vecs[v].ack_after) begin
        chk($sformatf("vec%0d_ack_valid", v), 32'(rx_valid), 32'h0);
        chk($sformatf("vec%0d_ack_ovr", v), 32'(rx_ovr), 32'h0);
      end
    end

    // Framing error followed by a 20-cycle break
    send_frame(6'h15, 1'b0, 1'b0, bcnt, pv);
    chk("brk_err", 32'(rx_err), 32'h1);
    chk("brk_valid", 32'(rx_valid), 32'h0);
    chk("brk_data", 32'(rx_data), 32'h33);
    ecnt = 0; vcnt = 0; bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      rx = 1'b0;
      tick();
      if (rx_err) ecnt++;
      if (rx_valid) vcnt++;
      if (rx_busy) bcnt++;
    end
    chk("brk_err_count", 32'(ecnt), 32'h0);
    chk("brk_valid_count", 32'(vcnt), 32'h0);
    chk("brk_busy_count", 32'(bcnt), 32'h0);
    rx = 1'b1; tick();
    send_frame(6'h3F, 1'b1, 1'b0, bcnt, pv);
    chk("post_brk_valid", 32'(rx_valid), 32'h1);
    chk("post_brk_data", 32'(rx_data), 32'h3F);
    chk("post_brk_err", 32'(rx_err), 32'h0);
    chk("post_brk_busy", 32'(bcnt), 32'd7);
    rx = 1'b1;

    // Reset after the 3rd data bit of a frame
    tick();
    rx = 1'b0; tick();
    rx = 1'b0; tick();
    rx = 1'b1; tick();
    rx = 1'b0; tick();
    chk("mid_busy", 32'(rx_busy), 32'h1);
    rst = 1'b1; rx = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_data", 32'(rx_data), 32'h0);
    chk("mid_rst_valid", 32'(rx_valid), 32'h0);
    chk("mid_rst_busy", 32'(rx_busy), 32'h0);
    chk("mid_rst_err", 32'(rx_err), 32'h0);
    chk("mid_rst_ovr", 32'(rx_ovr), 32'h0);
    tick();
    send_frame(6'h01, 1'b1, 1'b0, bcnt, pv);
    chk("post_rst_valid", 32'(rx_valid), 32'h1);
    chk("post_rst_data", 32'(rx_data), 32'h01);
    rx = 1'b1;
    rx_ack = 1'b1; tick(); rx_ack = 1'b0;
    chk("post_rst_ack", 32'(rx_valid), 32'h0);

    // Back-to-back frames with no gap, ack in each stop cycle
    for (int f = 0; f < 3; f++) begin
      send_frame(b2b[f], 1'b1, 1'b1, bcnt, pv);
      chk($sformatf("b2b%0d_valid", f), 32'(rx_valid), 32'h1);
      chk($sformatf("b2b%0d_data", f), 32'(rx_data), 32'(b2b[f]));
      chk($sformatf("b2b%0d_err", f), 32'(rx_err), 32'h0);
      chk($sformatf("b2b%0d_ovr", f), 32'(rx_ovr), 32'h0);
      chk($sformatf("b2b%0d_busy", f), 32'(bcnt), 32'd7);
    end
    rx = 1'b1;
    rx_ack = 1'b1; tick(); rx_ack = 1'b0;
    chk("b2b_final_valid", 32'(rx_valid), 32'h0);
    chk("b2b_final_data", 32'(rx_data), 32'h12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
